// File: rtl/display_pkg.sv
// Shared page encoding and default timing constants for the front-panel display sequencer.
package display_pkg;

  typedef enum logic [1:0] {
    PRICE    = 2'd0,
    STATS    = 2'd1,
    SNAP     = 2'd2,
    PAGE_BAD = 2'd3
  } page_e;

  localparam int DEF_TICK_DIV      = 500000;
  localparam int DEF_ROTATE_TICKS  = 300;
  localparam int DEF_BLINK_TICKS   = 25;
  localparam int DEF_STRETCH_TICKS = 10;

  // The illegal code falls back to PRICE so a corrupted state recovers in one cycle.
  function automatic page_e next_page(input page_e p);
    case (p)
      PRICE:   return STATS;
      STATS:   return SNAP;
      default: return PRICE;
    endcase
  endfunction

endpackage

// File: rtl/display_sequencer_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen
  import display_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_sequencer.sv
// Pages live engine values onto three HEX byte pairs, with halt blink and a stretched match LED.
// Optional auto-advance of the page is enabled by defining DISPLAY_SEQ_AUTOROTATE_EN.
module display_sequencer
  import display_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int ROTATE_TICKS  = DEF_ROTATE_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS,
  parameter int STRETCH_TICKS = DEF_STRETCH_TICKS
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] buy_price,
  input  logic [7:0] sell_price,
  input  logic [7:0] spread_now,
  input  logic [7:0] trade_count,
  input  logic [1:0] state,
  input  logic       halt_signal,
  input  logic       match_signal,
  input  logic       next_key,
  output logic [7:0] disp_lo,
  output logic [7:0] disp_mid,
  output logic [7:0] disp_hi,
  output logic [2:0] blank,
  output logic [1:0] page,
  output logic       match_led
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int SW = $clog2(STRETCH_TICKS + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH_TICKS);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Two synchronizer stages plus one history stage for falling-edge detection.
  logic key_s1_q, key_s2_q, key_s3_q;
  logic next_pulse;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_s3_q <= 1'b1;
    end else begin
      key_s1_q <= next_key;
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
    end
  end

  assign next_pulse = key_s3_q & ~key_s2_q;

  logic rot_expire;

`ifdef DISPLAY_SEQ_AUTOROTATE_EN
  localparam int RW = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_TICKS - 1);

  logic [RW-1:0] rot_cnt_q, rot_cnt_d;

  // A press takes priority and clears the count, so a coincident expiry cannot add a second step.
  always_comb begin
    rot_expire = 1'b0;
    rot_cnt_d  = rot_cnt_q;
    if (next_pulse) begin
      rot_cnt_d = '0;
    end else if (tick) begin
      if (rot_cnt_q == ROT_LAST) begin
        rot_expire = 1'b1;
        rot_cnt_d  = '0;
      end else begin
        rot_cnt_d = rot_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rot_cnt_q <= '0;
    else         rot_cnt_q <= rot_cnt_d;
  end
`else
  assign rot_expire = 1'b0;
`endif

  page_e page_state_q, page_state_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) page_state_q <= PRICE;
    else         page_state_q <= page_state_d;
  end

  always_comb begin
    page_state_d = page_state_q;
    if (page_state_q == PAGE_BAD || next_pulse || rot_expire)
      page_state_d = next_page(page_state_q);
  end

  // Match snapshot, halt blink and LED stretch state.
  logic          match_prev_q;
  logic          match_rise;
  logic [7:0]    snap_buy_q, snap_buy_d;
  logic [7:0]    snap_sell_q, snap_sell_d;
  logic [7:0]    snap_tc_q, snap_tc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [SW-1:0] str_cnt_q, str_cnt_d;

  assign match_rise = match_signal & ~match_prev_q;

  always_comb begin
    snap_buy_d  = snap_buy_q;
    snap_sell_d = snap_sell_q;
    snap_tc_d   = snap_tc_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    str_cnt_d   = str_cnt_q;

    if (match_rise) begin
      snap_buy_d  = buy_price;
      snap_sell_d = sell_price;
      snap_tc_d   = trade_count;
    end

    if (!halt_signal) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    if (match_rise)                     str_cnt_d = STRETCH_LD;
    else if (tick && str_cnt_q != '0)   str_cnt_d = str_cnt_q - SW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      match_prev_q <= 1'b0;
      snap_buy_q   <= '0;
      snap_sell_q  <= '0;
      snap_tc_q    <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      str_cnt_q    <= '0;
    end else begin
      match_prev_q <= match_signal;
      snap_buy_q   <= snap_buy_d;
      snap_sell_q  <= snap_sell_d;
      snap_tc_q    <= snap_tc_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      str_cnt_q    <= str_cnt_d;
    end
  end

  logic [7:0] disp_lo_q, disp_lo_d;
  logic [7:0] disp_mid_q, disp_mid_d;
  logic [7:0] disp_hi_q, disp_hi_d;
  logic [2:0] blank_q, blank_d;
  logic [1:0] page_q, page_d;
  logic       match_led_q, match_led_d;

  always_comb begin
    disp_lo_d  = '0;
    disp_mid_d = '0;
    disp_hi_d  = '0;
    case (page_state_q)
      PRICE: begin
        disp_lo_d  = buy_price;
        disp_mid_d = sell_price;
        disp_hi_d  = spread_now;
      end
      STATS: begin
        disp_lo_d  = trade_count;
        disp_mid_d = {6'b0, state};
        disp_hi_d  = {7'b0, halt_signal};
      end
      SNAP: begin
        disp_lo_d  = snap_buy_q;
        disp_mid_d = snap_sell_q;
        disp_hi_d  = snap_tc_q;
      end
      default: ;
    endcase
    page_d      = page_state_q;
    blank_d     = (halt_signal && blink_off_q) ? 3'b111 : 3'b000;
    match_led_d = (str_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_lo_q   <= '0;
      disp_mid_q  <= '0;
      disp_hi_q   <= '0;
      blank_q     <= '0;
      page_q      <= PRICE;
      match_led_q <= 1'b0;
    end else begin
      disp_lo_q   <= disp_lo_d;
      disp_mid_q  <= disp_mid_d;
      disp_hi_q   <= disp_hi_d;
      blank_q     <= blank_d;
      page_q      <= page_d;
      match_led_q <= match_led_d;
    end
  end

  assign disp_lo   = disp_lo_q;
  assign disp_mid  = disp_mid_q;
  assign disp_hi   = disp_hi_q;
  assign blank     = blank_q;
  assign page      = page_q;
  assign match_led = match_led_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: directed stimulus queues expected values, a monitor checks them.
module tb_display_sequencer;

  localparam int TICK_DIV      = 4;
  localparam int ROTATE_TICKS  = 5;
  localparam int BLINK_TICKS   = 2;
  localparam int STRETCH_TICKS = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] buy_price, sell_price, spread_now, trade_count;
  logic [1:0] state_in;
  logic       halt_signal, match_signal, next_key;
  logic [7:0] disp_lo, disp_mid, disp_hi;
  logic [2:0] blank;
  logic [1:0] page;
  logic       match_led;

  always #5 clk = ~clk;

  display_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .ROTATE_TICKS  (ROTATE_TICKS),
    .BLINK_TICKS   (BLINK_TICKS),
    .STRETCH_TICKS (STRETCH_TICKS)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .spread_now   (spread_now),
    .trade_count  (trade_count),
    .state        (state_in),
    .halt_signal  (halt_signal),
    .match_signal (match_signal),
    .next_key     (next_key),
    .disp_lo      (disp_lo),
    .disp_mid     (disp_mid),
    .disp_hi      (disp_hi),
    .blank        (blank),
    .page         (page),
    .match_led    (match_led)
  );

  typedef enum {F_PAGE, F_LO, F_MID, F_HI, F_BLANK, F_LED} field_e;

  typedef struct {
    int         due;
    field_e     f;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input field_e f);
    case (f)
      F_PAGE:  return {6'b0, page};
      F_LO:    return disp_lo;
      F_MID:   return disp_mid;
      F_HI:    return disp_hi;
      F_BLANK: return {5'b0, blank};
      default: return {7'b0, match_led};
    endcase
  endfunction

  // Monitor: compares every expectation that has come due, half a cycle after the active edge.
  exp_t       mon_e;
  logic [7:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = sample(mon_e.f);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h (cycle %0d)", mon_e.name, mon_act, mon_e.val, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(input field_e f, input logic [7:0] v, input string n);
    sb.push_back('{cyc, f, v, n});
  endtask

  task automatic press();
    next_key = 1'b0;
    step(10);
    next_key = 1'b1;
    step(10);
  endtask

  initial begin
    resetn       = 1'b0;
    buy_price    = '0;
    sell_price   = '0;
    spread_now   = '0;
    trade_count  = '0;
    state_in     = '0;
    halt_signal  = 1'b0;
    match_signal = 1'b0;
    next_key     = 1'b1;
    step(2);
    want(F_PAGE, 8'h00, "rst_page");
    want(F_LO, 8'h00, "rst_lo");
    want(F_BLANK, 8'h00, "rst_blank");
    want(F_LED, 8'h00, "rst_led");
    step(1);

    // Price page after release.
    buy_price   = 8'h12;
    sell_price  = 8'h15;
    spread_now  = 8'h03;
    trade_count = 8'h42;
    state_in    = 2'b10;
    resetn      = 1'b1;
    step(2);
    want(F_LO, 8'h12, "price_lo");
    want(F_MID, 8'h15, "price_mid");
    want(F_HI, 8'h03, "price_hi");
    want(F_PAGE, 8'h00, "price_page");

    press();
    want(F_PAGE, 8'h01, "stats_page");
    want(F_LO, 8'h42, "stats_lo");
    want(F_MID, 8'h02, "stats_mid");
    want(F_HI, 8'h00, "stats_hi_run");
    halt_signal = 1'b1;
    step(2);
    want(F_HI, 8'h01, "stats_hi_halt");
    want(F_BLANK, 8'h00, "halt_starts_visible");
    halt_signal = 1'b0;
    step(1);

    press();
    want(F_PAGE, 8'h02, "snap_page");
    want(F_LO, 8'h00, "snap_empty_lo");
    want(F_MID, 8'h00, "snap_empty_mid");
    want(F_HI, 8'h00, "snap_empty_hi");

    press();
    want(F_PAGE, 8'h00, "wrap_page");
    want(F_LO, 8'h12, "wrap_lo");

    // Snapshot capture on match rise, then live values move on.
    buy_price    = 8'h20;
    sell_price   = 8'h1F;
    trade_count  = 8'h07;
    match_signal = 1'b1;
    step(1);
    want(F_LED, 8'h01, "match_led_set");
    match_signal = 1'b0;
    buy_price    = 8'hAA;
    sell_price   = 8'hBB;
    trade_count  = 8'hCC;
    spread_now   = 8'hDD;
    step(1);
    press();
    press();
    want(F_PAGE, 8'h02, "snap_page2");
    want(F_LO, 8'h20, "snap_lo");
    want(F_MID, 8'h1F, "snap_mid");
    want(F_HI, 8'h07, "snap_hi");

    // Reset mid-stretch clears outputs at once.
    match_signal = 1'b1;
    step(1);
    match_signal = 1'b0;
    resetn = 1'b0;
    #1;
    want(F_LED, 8'h00, "async_rst_led");
    want(F_PAGE, 8'h00, "async_rst_page");
    want(F_LO, 8'h00, "async_rst_lo");
    step(2);

    // Halt blink: toggle every 2 ticks = 8 clocks, visible first.
    halt_signal = 1'b1;
    resetn      = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step(1);
      want(F_BLANK, (((k - 1) / 8) % 2 == 1) ? 8'h07 : 8'h00, $sformatf("blink_k%0d", k));
    end
    halt_signal = 1'b0;
    step(1);
    want(F_BLANK, 8'h00, "halt_fall_unblank");
    step(8);
    want(F_BLANK, 8'h00, "halt_off_steady");

    // Match stretch with a reload at cycle 8.
    resetn = 1'b0;
    step(2);
    match_signal = 1'b1;
    resetn       = 1'b1;
    step(1);
    match_signal = 1'b0;
    want(F_LED, 8'h01, "stretch_k1");
    for (int k = 2; k <= 24; k++) begin
      step(1);
      if (k == 8) match_signal = 1'b1;
      if (k == 9) match_signal = 1'b0;
      want(F_LED, (k <= 19) ? 8'h01 : 8'h00, $sformatf("stretch_k%0d", k));
    end

    // Auto-rotate behaviour.
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
`ifdef DISPLAY_SEQ_AUTOROTATE_EN
    for (int k = 1; k <= 62; k++) begin
      step(1);
      if (k == 37) next_key = 1'b0;
      if (k == 47) next_key = 1'b1;
      if (k == 20) want(F_PAGE, 8'h00, "rot_before");
      if (k == 22) want(F_PAGE, 8'h01, "rot_after");
      if (k == 42) want(F_PAGE, 8'h02, "rot_coincide");
      if (k == 59) want(F_PAGE, 8'h02, "rot_cleared");
      if (k == 62) want(F_PAGE, 8'h00, "rot_next");
    end
`else
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (k == 50)  want(F_PAGE, 8'h00, "idle_page_50");
      if (k == 100) want(F_PAGE, 8'h00, "idle_page_100");
    end
`endif

    step(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
